sh7034_bus_target: RTL and testbench

External-bus responder for the SH7034 (SH-1) 16-bit bus. It decodes one chip-select area, stretches the cycle with WAIT_N, and completes each access through a 32-bit request/acknowledge memory port (BRAM/SDRAM arbiter side). It sits between the SH7034 bus pins and the CD-block memory or peripheral it serves, as the target of the BSC's T1/T2/wait cycles.

---
 rtl/sh7034_bus_target_pkg.sv | 19 +
 rtl/sh7034_bus_target_if.sv | 31 +++
 rtl/sh7034_tgt_pbuf.sv | 37 +++
 rtl/sh7034_bus_target.sv | 121 ++++++++++++
 tb/tb_sh7034_bus_target.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sh7034_bus_target_pkg.sv
// Shared types and constants for the SH7034 external-bus target.
// Optional read prefetch is enabled with SH7034_TGT_PREFETCH_EN.
package sh7034_bus_target_pkg;

  localparam logic [2:0] AREA   = 3'd2;
  localparam int         MEM_AW = 22;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } tgt_state_t;

  // Big-endian lane select: A[1]=0 addresses the upper halfword (bits 31:16).
  function automatic logic [3:0] be_map(input logic a1, input logic hi, input logic lo);
    return a1 ? {2'b00, hi, lo} : {hi, lo, 2'b00};
  endfunction

endpackage

// File: rtl/sh7034_bus_target_if.sv
// SH7034 bus pins plus the 32-bit request/acknowledge memory port.
interface sh7034_bus_target_if;
  import sh7034_bus_target_pkg::*;

  logic [23:0]       bus_a;
  logic [15:0]       bus_di;
  logic [15:0]       bus_do;
  logic [7:0]        cs_n;
  logic              rd_n;
  logic              wrh_n;
  logic              wrl_n;
  logic              wait_n;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_a;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_do;
  logic [31:0]       mem_di;
  logic              mem_ack;

  modport slave (
    input  bus_a, bus_di, cs_n, rd_n, wrh_n, wrl_n, mem_di, mem_ack,
    output bus_do, wait_n, mem_req, mem_a, mem_we, mem_be, mem_do
  );

  modport master (
    output bus_a, bus_di, cs_n, rd_n, wrh_n, wrl_n, mem_di, mem_ack,
    input  bus_do, wait_n, mem_req, mem_a, mem_we, mem_be, mem_do
  );

endinterface

// File: rtl/sh7034_tgt_pbuf.sv
// One-entry read prefetch buffer (tag/data/valid); only built when
// SH7034_TGT_PREFETCH_EN is defined.
`ifdef SH7034_TGT_PREFETCH_EN
module sh7034_tgt_pbuf
  import sh7034_bus_target_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic              inval,
  input  logic [MEM_AW-1:0] fill_tag,
  input  logic [31:0]       fill_data,
  input  logic [MEM_AW-1:0] look_tag,
  output logic              hit,
  output logic [31:0]       data
);

  logic              vld;
  logic [MEM_AW-1:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld <= 1'b0;
    else if (inval) vld <= 1'b0;
    else if (fill)  vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag  <= fill_tag;
      data <= fill_data;
    end
  end

  assign hit = vld & (tag == look_tag);

endmodule
`endif

// File: rtl/sh7034_bus_target.sv
// SH7034 chip-select area responder: stretches the bus cycle with WAIT_N and
// completes it over a 32-bit req/ack port. Optional prefetch: SH7034_TGT_PREFETCH_EN.
module sh7034_bus_target
  import sh7034_bus_target_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  sh7034_bus_target_if.slave bus
);

  tgt_state_t  state;
  logic        acc, acc_q, start, launch, is_wr;
  logic        rdy, pend, defer, a1_q;
  logic        hit;
  logic [15:0] hit_half;
  logic [3:0]  rd_be;

  assign acc    = ~bus.cs_n[AREA] & (~bus.rd_n | ~bus.wrh_n | ~bus.wrl_n);
  assign start  = acc & ~acc_q;
  assign is_wr  = ~bus.wrh_n | ~bus.wrl_n;
  // A start seen while an abandoned request is outstanding is held in defer.
  assign launch = (state == IDLE) & ~pend & acc & (start | defer);
  assign bus.wait_n = ~(acc & ~rdy);

`ifdef SH7034_TGT_PREFETCH_EN
  logic        fill;
  logic [31:0] pbuf_data;

  assign fill     = (state == REQ) & bus.mem_ack & ~bus.mem_we;
  assign rd_be    = 4'b1111;
  assign hit_half = bus.bus_a[1] ? pbuf_data[15:0] : pbuf_data[31:16];

  sh7034_tgt_pbuf u_pbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill      (fill),
    .inval     (launch & is_wr),
    .fill_tag  (bus.mem_a),
    .fill_data (bus.mem_di),
    .look_tag  (bus.bus_a[23:2]),
    .hit       (hit),
    .data      (pbuf_data)
  );
`else
  assign rd_be    = be_map(bus.bus_a[1], 1'b1, 1'b1);
  assign hit      = 1'b0;
  assign hit_half = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_q       <= 1'b0;
      rdy         <= 1'b0;
      pend        <= 1'b0;
      defer       <= 1'b0;
      a1_q        <= 1'b0;
      bus.bus_do  <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_a   <= '0;
      bus.mem_we  <= 1'b0;
      bus.mem_be  <= '0;
      bus.mem_do  <= '0;
    end else begin
      acc_q <= acc;
      case (state)
        IDLE: begin
          if (pend) begin
            if (bus.mem_ack) begin
              bus.mem_req <= 1'b0;
              pend        <= 1'b0;
            end
            defer <= acc & (defer | start);
          end else if (launch) begin
            defer <= 1'b0;
            if (!is_wr && hit) begin
              bus.bus_do <= hit_half;
              rdy        <= 1'b1;
              state      <= DONE;
            end else begin
              rdy         <= 1'b0;
              bus.mem_req <= 1'b1;
              bus.mem_a   <= bus.bus_a[23:2];
              a1_q        <= bus.bus_a[1];
              bus.mem_we  <= is_wr;
              bus.mem_be  <= is_wr ? be_map(bus.bus_a[1], ~bus.wrh_n, ~bus.wrl_n) : rd_be;
              bus.mem_do  <= {bus.bus_di, bus.bus_di};
              state       <= REQ;
            end
          end else begin
            defer <= 1'b0;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (acc) begin
              if (!bus.mem_we) bus.bus_do <= a1_q ? bus.mem_di[15:0] : bus.mem_di[31:16];
              rdy   <= 1'b1;
              state <= DONE;
            end else begin
              state <= IDLE;
            end
          end else if (!acc) begin
            // Master gave up: keep the request alive until the memory acks it.
            pend  <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: begin
          if (!acc) begin
            rdy   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sh7034_bus_target.sv
// Directed bench for sh7034_bus_target; expectations follow SH7034_TGT_PREFETCH_EN.
module tb_sh7034_bus_target;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   req_cnt;

  sh7034_bus_target_if bif ();

  sh7034_bus_target dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bif.mem_req) req_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bif.cs_n  = 8'hFF;
    bif.rd_n  = 1'b1;
    bif.wrh_n = 1'b1;
    bif.wrl_n = 1'b1;
  endtask

  task automatic ack(input logic [31:0] d);
    bif.mem_ack = 1'b1;
    bif.mem_di  = d;
    tick();
    bif.mem_ack = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    req_cnt = 0;
    rst_n   = 1'b0;
    idle_bus();
    bif.bus_a   = '0;
    bif.bus_di  = '0;
    bif.mem_di  = '0;
    bif.mem_ack = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_wait_n",  bif.wait_n,  1);
    check("rst_mem_req", bif.mem_req, 0);
    check("rst_bus_do",  bif.bus_do,  0);
    check("rst_mem_a",   bif.mem_a,   0);
    check("rst_mem_be",  bif.mem_be,  0);
    rst_n = 1'b1;

    // Halfword read at 0x000102, ack after 3 CLK
    tick();
    req_cnt   = 0;
    bif.cs_n  = 8'hFB;
    bif.rd_n  = 1'b0;
    bif.bus_a = 24'h000102;
    @(negedge clk);
    check("rd_wait_early", bif.wait_n, 0);
    tick();
    @(negedge clk);
    check("rd_mem_req", bif.mem_req, 1);
    check("rd_mem_a",   bif.mem_a,   32'h40);
    check("rd_mem_we",  bif.mem_we,  0);
`ifdef SH7034_TGT_PREFETCH_EN
    check("rd_mem_be",  bif.mem_be,  4'b1111);
`else
    check("rd_mem_be",  bif.mem_be,  4'b0011);
`endif
    tick(); tick();
    @(negedge clk);
    check("rd_wait_hold", bif.wait_n, 0);
    tick();
    bif.mem_ack = 1'b1;
    bif.mem_di  = 32'h11223344;
    @(negedge clk);
    check("rd_wait_at_ack", bif.wait_n, 0);
    tick();
    bif.mem_ack = 1'b0;
    @(negedge clk);
    check("rd_wait_rise", bif.wait_n,  1);
    check("rd_bus_do",    bif.bus_do,  16'h3344);
    check("rd_req_drop",  bif.mem_req, 0);
    check("rd_req_cnt",   req_cnt,     1);
    tick();
    idle_bus();
    tick();
    @(negedge clk);
    check("rd_release_wait", bif.wait_n, 1);

    // Upper-byte write at 0x000200
    tick();
    req_cnt    = 0;
    bif.cs_n   = 8'hFB;
    bif.wrh_n  = 1'b0;
    bif.bus_a  = 24'h000200;
    bif.bus_di = 16'hABCD;
    @(negedge clk);
    check("wr_wait_early", bif.wait_n, 0);
    tick();
    @(negedge clk);
    check("wr_mem_we", bif.mem_we, 1);
    check("wr_mem_be", bif.mem_be, 4'b1000);
    check("wr_mem_do", bif.mem_do, 32'hABCDABCD);
    check("wr_mem_a",  bif.mem_a,  32'h80);
    tick();
    ack(32'h0);
    @(negedge clk);
    check("wr_wait_rise", bif.wait_n,  1);
    check("wr_req_drop",  bif.mem_req, 0);
    check("wr_req_cnt",   req_cnt,     1);
    idle_bus();
    tick();

    // 32-bit master read: halfwords 0x000300 and 0x000302 under held CS_N
    tick();
    req_cnt   = 0;
    bif.cs_n  = 8'hFB;
    bif.rd_n  = 1'b0;
    bif.bus_a = 24'h000300;
    tick();
    @(negedge clk);
    check("l_first_req", bif.mem_req, 1);
    check("l_first_a",   bif.mem_a,   32'hC0);
    tick();
    ack(32'hCAFEBEEF);
    @(negedge clk);
    check("l_first_wait", bif.wait_n, 1);
    check("l_first_do",   bif.bus_do, 16'hCAFE);
    tick();
    bif.rd_n  = 1'b1;
    bif.bus_a = 24'h000302;
    tick();
    bif.rd_n = 1'b0;
    @(negedge clk);
    check("l_second_wait_low", bif.wait_n, 0);
    tick();
    @(negedge clk);
`ifdef SH7034_TGT_PREFETCH_EN
    check("l_hit_wait", bif.wait_n,  1);
    check("l_hit_do",   bif.bus_do,  16'hBEEF);
    check("l_hit_req",  bif.mem_req, 0);
    check("l_req_cnt",  req_cnt,     1);
`else
    check("l_second_req", bif.mem_req, 1);
    check("l_second_a",   bif.mem_a,   32'hC0);
    check("l_req_cnt",    req_cnt,     2);
    tick();
    ack(32'hCAFEBEEF);
    @(negedge clk);
    check("l_second_wait", bif.wait_n, 1);
    check("l_second_do",   bif.bus_do, 16'hBEEF);
`endif
    idle_bus();
    tick();

    // Write to 0x000300 then read 0x000302: must go to memory
    tick();
    bif.cs_n   = 8'hFB;
    bif.wrh_n  = 1'b0;
    bif.wrl_n  = 1'b0;
    bif.bus_a  = 24'h000300;
    bif.bus_di = 16'h1234;
    tick();
    @(negedge clk);
    check("inv_wr_be", bif.mem_be, 4'b1100);
    tick();
    ack(32'h0);
    idle_bus();
    tick();
    req_cnt   = 0;
    bif.cs_n  = 8'hFB;
    bif.rd_n  = 1'b0;
    bif.bus_a = 24'h000302;
    tick();
    @(negedge clk);
    check("inv_rd_req", bif.mem_req, 1);
    check("inv_rd_cnt", req_cnt,     1);
    tick();
    ack(32'h9999AAAA);
    @(negedge clk);
    check("inv_rd_do", bif.bus_do, 16'hAAAA);
    idle_bus();
    tick();

    // Strobe dropped in REQ, new read started before the old ack
    tick();
    req_cnt   = 0;
    bif.cs_n  = 8'hFB;
    bif.rd_n  = 1'b0;
    bif.bus_a = 24'h000400;
    tick();
    @(negedge clk);
    check("ab_req", bif.mem_req, 1);
    tick();
    idle_bus();
    tick();
    @(negedge clk);
    check("ab_req_kept", bif.mem_req, 1);
    check("ab_wait_idle", bif.wait_n, 1);
    tick();
    bif.cs_n  = 8'hFB;
    bif.rd_n  = 1'b0;
    bif.bus_a = 24'h000404;
    @(negedge clk);
    check("ab_new_wait", bif.wait_n, 0);
    tick();
    @(negedge clk);
    check("ab_old_a",    bif.mem_a,  32'h100);
    check("ab_wait_pend", bif.wait_n, 0);
    tick();
    ack(32'h55556666);
    @(negedge clk);
    check("ab_req_gap",  bif.mem_req, 0);
    check("ab_discard",  bif.bus_do,  16'hAAAA);
    check("ab_wait_gap", bif.wait_n,  0);
    tick();
    @(negedge clk);
    check("ab_new_req",  bif.mem_req, 1);
    check("ab_new_a",    bif.mem_a,   32'h101);
    check("ab_wait_new", bif.wait_n,  0);
    check("ab_req_cnt",  req_cnt,     2);
    tick();
    ack(32'h77778888);
    @(negedge clk);
    check("ab_new_do",   bif.bus_do,  16'h7777);
    check("ab_new_wait_rise", bif.wait_n, 1);
    idle_bus();
    tick();

    // Asynchronous reset in the middle of a request
    tick();
    bif.cs_n  = 8'hFB;
    bif.rd_n  = 1'b0;
    bif.bus_a = 24'h000500;
    tick();
    @(negedge clk);
    check("ar_req", bif.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req_drop", bif.mem_req, 0);
    check("ar_bus_do",   bif.bus_do,  0);
    check("ar_mem_a",    bif.mem_a,   0);
    idle_bus();
    #1;
    check("ar_wait", bif.wait_n, 1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
